// File: rtl/game_pkg.sv
// Shared definitions for the memory-game step logic: step codes, board geometry,
// judge FSM encoding and the square colour lookup.
package game_pkg;

    localparam logic [3:0] STEP_ES2   = 4'b0100;
    localparam logic [3:0] STEP_FIRST = 4'b0001;
    localparam logic [3:0] STEP_OVER  = 4'b1000;

    localparam int IDX_W  = 3;
    localparam int COL_W  = 3;
    localparam int NUM_SQ = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SHOW   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_OVER   = 3'd4
    } judge_state_t;

    // Square k occupies colors[3k+2:3k].
    function automatic logic [COL_W-1:0] color_of(
        input logic [NUM_SQ*COL_W-1:0] colors,
        input logic [IDX_W-1:0]        idx
    );
        return colors[int'(idx)*COL_W +: COL_W];
    endfunction

endpackage

// File: rtl/match_judge_verdict_timer.sv
// Loadable up-counter that flags the last cycle of the verdict display window.
module verdict_timer #(
    parameter int SHOW_CYCLES = 25_000_000
) (
    input  logic clk25MHz,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int CW = (SHOW_CYCLES > 2) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SHOW_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign done = en && (count == LAST);

endmodule

// File: rtl/match_judge.sv
// Judges a confirmed pair of squares, shows the verdict for SHOW_CYCLES cycles,
// then books the result and asks the step controller for the next step.
module match_judge
    import game_pkg::*;
#(
    parameter int SHOW_CYCLES = 25_000_000
) (
    input  logic        clk25MHz,
    input  logic        reset,
    input  logic        enter,
    input  logic [3:0]  step_2,
    input  logic [2:0]  es1,
    input  logic [2:0]  es2,
    input  logic [23:0] colors,
    output logic        show,
    output logic        hit,
    output logic        reject,
    output logic        step_adv,
    output logic [3:0]  step_next,
    output logic [7:0]  matched_mask,
    output logic [2:0]  score,
    output logic [7:0]  tries,
    output logic [2:0]  dbg_state
);

    // step_adv is a one-cycle strobe with no back-pressure: step_next is valid only
    // while step_adv is high and the step register must load it in that same cycle.

    judge_state_t state, state_nx;
    logic         enter_q;
    logic [2:0]   a1, a2;
    logic         timer_done;
    logic         confirm, take, pair_bad;
    logic [7:0]   pair_bits, mask_upd;

    assign confirm   = enter && !enter_q;
    assign take      = confirm && (step_2 == STEP_ES2);
    assign pair_bad  = (es1 == es2) || matched_mask[es1] || matched_mask[es2];
    assign pair_bits = (8'b1 << a1) | (8'b1 << a2);
    assign mask_upd  = hit ? (matched_mask | pair_bits) : matched_mask;
    assign dbg_state = state;

    verdict_timer #(.SHOW_CYCLES(SHOW_CYCLES)) u_timer (
        .clk25MHz (clk25MHz),
        .reset    (reset),
        .load     (state == ST_CHECK),
        .en       (state == ST_SHOW),
        .done     (timer_done)
    );

    always_ff @(posedge clk25MHz) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        step_adv  = 1'b0;
        step_next = STEP_FIRST;
        case (state)
            ST_IDLE:   if (take && !pair_bad) state_nx = ST_CHECK;
            ST_CHECK:  state_nx = ST_SHOW;
            ST_SHOW:   if (timer_done) state_nx = ST_COMMIT;
            ST_COMMIT: begin
                step_adv = 1'b1;
                if (mask_upd == 8'hFF) begin
                    step_next = STEP_OVER;
                    state_nx  = ST_OVER;
                end else begin
                    state_nx  = ST_IDLE;
                end
            end
            ST_OVER:   state_nx = ST_OVER;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            enter_q      <= 1'b0;
            a1           <= '0;
            a2           <= '0;
            show         <= 1'b0;
            hit          <= 1'b0;
            reject       <= 1'b0;
            matched_mask <= '0;
            score        <= '0;
            tries        <= '0;
        end else begin
            enter_q <= enter;
            reject  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        if (pair_bad) begin
                            reject <= 1'b1;
                        end else begin
                            a1 <= es1;
                            a2 <= es2;
                        end
                    end
                end
                ST_CHECK: begin
                    // Colours are sampled only here, so later board changes leave hit alone.
                    hit  <= (color_of(colors, a1) == color_of(colors, a2));
                    show <= 1'b1;
                    if (tries != 8'hFF) tries <= tries + 8'd1;
                end
                ST_SHOW: begin
                    if (timer_done) show <= 1'b0;
                end
                ST_COMMIT: begin
                    if (hit) begin
                        matched_mask <= mask_upd;
                        if (score != 3'd4) score <= score + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_match_judge.sv
// Directed bench for match_judge with a 4-cycle verdict window.
module tb_match_judge;

    logic        clk25MHz = 1'b0;
    logic        reset = 1'b1;
    logic        enter = 1'b0;
    logic [3:0]  step_2 = 4'b0100;
    logic [2:0]  es1 = '0;
    logic [2:0]  es2 = '0;
    logic [23:0] colors;
    logic        show, hit, reject, step_adv;
    logic [3:0]  step_next;
    logic [7:0]  matched_mask;
    logic [2:0]  score;
    logic [7:0]  tries;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    // sq7..sq0 = 7,7,2,4,1,4,1,2: pairs (0,5) (1,3) (2,4) (6,7)
    localparam logic [23:0] BOARD = {3'd7, 3'd7, 3'd2, 3'd4, 3'd1, 3'd4, 3'd1, 3'd2};

    // Observations from the last run_confirm call
    int         r_show_start, r_show_len, r_adv, r_rej;
    logic [3:0] r_nx;
    logic       r_hit;

    always #20 clk25MHz = ~clk25MHz;

    match_judge #(.SHOW_CYCLES(4)) dut (
        .clk25MHz     (clk25MHz),
        .reset        (reset),
        .enter        (enter),
        .step_2       (step_2),
        .es1          (es1),
        .es2          (es2),
        .colors       (colors),
        .show         (show),
        .hit          (hit),
        .reject       (reject),
        .step_adv     (step_adv),
        .step_next    (step_next),
        .matched_mask (matched_mask),
        .score        (score),
        .tries        (tries),
        .dbg_state    (dbg_state)
    );

    task automatic tick();
        @(posedge clk25MHz);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enter  = 1'b0;
        step_2 = 4'b0100;
        colors = BOARD;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Raise enter for 'hold' cycles with the given pair and watch 30 cycles.
    // Cycle 0 is the cycle in which enter first goes high.
    task automatic run_confirm(input logic [2:0] e1, input logic [2:0] e2,
                               input int hold, input bit scramble);
        r_show_start = -1;
        r_show_len   = 0;
        r_adv        = 0;
        r_rej        = 0;
        r_nx         = 4'h0;
        r_hit        = 1'bx;
        es1   = e1;
        es2   = e2;
        enter = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk25MHz);
            if (show) begin
                if (r_show_start < 0) r_show_start = k;
                r_show_len++;
                r_hit = hit;
            end
            if (step_adv) begin
                r_adv++;
                r_nx = step_next;
            end
            if (reject) r_rej++;
            tick();
            if (k + 1 == hold) enter = 1'b0;
            if (scramble && k == 3) colors = colors ^ 24'h000007;
        end
        enter = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk25MHz);
        checks++;
        if ({show, hit, reject, step_adv, matched_mask, score, tries} !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs: show=%b hit=%b rej=%b adv=%b mask=%h score=%0d tries=%0d, want all 0",
                     show, hit, reject, step_adv, matched_mask, score, tries);
        end
        checks++;
        if (step_next !== 4'b0001 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_step: step_next=%b state=%0d, want 0001 / 0", step_next, dbg_state);
        end
        tick();
    endtask

    task automatic test_hit();
        run_confirm(3'd0, 3'd5, 1, 1'b0);
        checks++;
        if (r_show_start !== 2 || r_show_len !== 4) begin
            errors++;
            $display("FAIL hit_show_window: start=%0d len=%0d, want 2 / 4", r_show_start, r_show_len);
        end
        checks++;
        if (r_hit !== 1'b1 || r_adv !== 1 || r_nx !== 4'b0001 || r_rej !== 0) begin
            errors++;
            $display("FAIL hit_verdict: hit=%b adv=%0d next=%b rej=%0d, want 1 / 1 / 0001 / 0",
                     r_hit, r_adv, r_nx, r_rej);
        end
        checks++;
        if (matched_mask !== 8'h21 || score !== 3'd1 || tries !== 8'd1) begin
            errors++;
            $display("FAIL hit_totals: mask=%h score=%0d tries=%0d, want 21 / 1 / 1",
                     matched_mask, score, tries);
        end
    endtask

    task automatic test_reject();
        run_confirm(3'd3, 3'd3, 1, 1'b0);
        checks++;
        if (r_rej !== 1 || r_show_len !== 0 || r_adv !== 0) begin
            errors++;
            $display("FAIL reject_same: rej=%0d show=%0d adv=%0d, want 1 / 0 / 0", r_rej, r_show_len, r_adv);
        end
        run_confirm(3'd0, 3'd4, 1, 1'b0);
        checks++;
        if (r_rej !== 1 || r_show_len !== 0 || matched_mask !== 8'h21 || tries !== 8'd1) begin
            errors++;
            $display("FAIL reject_matched: rej=%0d show=%0d mask=%h tries=%0d, want 1 / 0 / 21 / 1",
                     r_rej, r_show_len, matched_mask, tries);
        end
        run_confirm(3'd1, 3'd3, 20, 1'b0);
        checks++;
        if (r_show_len !== 4 || r_adv !== 1 || tries !== 8'd2 || matched_mask !== 8'h2B || score !== 3'd2) begin
            errors++;
            $display("FAIL held_enter: show=%0d adv=%0d tries=%0d mask=%h score=%0d, want 4 / 1 / 2 / 2b / 2",
                     r_show_len, r_adv, tries, matched_mask, score);
        end
    endtask

    task automatic test_miss();
        do_reset();
        run_confirm(3'd1, 3'd2, 1, 1'b0);
        checks++;
        if (r_hit !== 1'b0 || r_show_len !== 4 || r_adv !== 1 || r_nx !== 4'b0001) begin
            errors++;
            $display("FAIL miss_verdict: hit=%b show=%0d adv=%0d next=%b, want 0 / 4 / 1 / 0001",
                     r_hit, r_show_len, r_adv, r_nx);
        end
        checks++;
        if (matched_mask !== 8'h00 || score !== 3'd0 || tries !== 8'd1) begin
            errors++;
            $display("FAIL miss_totals: mask=%h score=%0d tries=%0d, want 00 / 0 / 1",
                     matched_mask, score, tries);
        end
    endtask

    task automatic test_completion();
        logic [2:0] pa [4] = '{3'd0, 3'd1, 3'd2, 3'd6};
        logic [2:0] pb [4] = '{3'd5, 3'd3, 3'd4, 3'd7};
        logic [3:0] want_nx;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_confirm(pa[i], pb[i], 1, 1'b0);
            want_nx = (i == 3) ? 4'b1000 : 4'b0001;
            checks++;
            if (r_adv !== 1 || r_nx !== want_nx || r_hit !== 1'b1) begin
                errors++;
                $display("FAIL complete_round%0d: adv=%0d next=%b hit=%b, want 1 / %b / 1",
                         i, r_adv, r_nx, r_hit, want_nx);
            end
        end
        checks++;
        if (matched_mask !== 8'hFF || score !== 3'd4 || tries !== 8'd4 || dbg_state !== 3'd4) begin
            errors++;
            $display("FAIL complete_final: mask=%h score=%0d tries=%0d state=%0d, want ff / 4 / 4 / 4",
                     matched_mask, score, tries, dbg_state);
        end
        run_confirm(3'd0, 3'd1, 1, 1'b0);
        checks++;
        if (r_show_len !== 0 || r_rej !== 0 || r_adv !== 0 || tries !== 8'd4 || dbg_state !== 3'd4) begin
            errors++;
            $display("FAIL over_absorbing: show=%0d rej=%0d adv=%0d tries=%0d state=%0d, want 0 / 0 / 0 / 4 / 4",
                     r_show_len, r_rej, r_adv, tries, dbg_state);
        end
    endtask

    task automatic test_reset_show();
        int adv_seen;
        do_reset();
        es1   = 3'd0;
        es2   = 3'd5;
        enter = 1'b1;
        tick();
        tick();
        tick();
        // Now in the second cycle of SHOW; the next edge samples reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        enter = 1'b0;
        @(negedge clk25MHz);
        checks++;
        if ({show, hit, reject, step_adv, matched_mask, score, tries} !== 22'd0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_show: show=%b hit=%b adv=%b mask=%h score=%0d tries=%0d state=%0d, want all 0",
                     show, hit, step_adv, matched_mask, score, tries, dbg_state);
        end
        adv_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk25MHz);
            if (step_adv || show) adv_seen++;
        end
        checks++;
        if (adv_seen !== 0) begin
            errors++;
            $display("FAIL reset_no_adv: adv/show cycles=%0d, want 0", adv_seen);
        end
        tick();
        run_confirm(3'd0, 3'd5, 1, 1'b0);
        checks++;
        if (r_show_len !== 4 || r_adv !== 1 || matched_mask !== 8'h21 || tries !== 8'd1) begin
            errors++;
            $display("FAIL reset_recover: show=%0d adv=%0d mask=%h tries=%0d, want 4 / 1 / 21 / 1",
                     r_show_len, r_adv, matched_mask, tries);
        end
    endtask

    task automatic test_gating();
        do_reset();
        step_2 = 4'b0011;
        run_confirm(3'd0, 3'd5, 1, 1'b0);
        checks++;
        if (r_show_len !== 0 || r_rej !== 0 || tries !== 8'd0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL gate_step: show=%0d rej=%0d tries=%0d state=%0d, want 0 / 0 / 0 / 0",
                     r_show_len, r_rej, tries, dbg_state);
        end
        step_2 = 4'b0100;
        run_confirm(3'd0, 3'd5, 1, 1'b1);
        checks++;
        if (r_hit !== 1'b1 || r_show_len !== 4 || matched_mask !== 8'h21) begin
            errors++;
            $display("FAIL colors_frozen: hit=%b show=%0d mask=%h, want 1 / 4 / 21",
                     r_hit, r_show_len, matched_mask);
        end
    endtask

    initial begin
        colors = BOARD;
        test_reset();
        test_hit();
        test_reject();
        test_miss();
        test_completion();
        test_reset_show();
        test_gating();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
